sdram_burst_sequencer: RTL and testbench

Upstream front-end for `sdram_controller`. It accepts one burst command of N words, either read or write, from the DMA/bus side. It breaks the burst into single-word requests on the controller's `in_valid`/`busy` handshake and honours the controller's one-deep queue. Write data arrives on a valid/ready stream; read data returns through an in-order, credit-guarded return FIFO.

---
 rtl/sdram_burst_sequencer.sv | 116 +++++++++++
 tb/tb_sdram_burst_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_sequencer.sv
// sdram_burst_sequencer: splits burst commands into single-word sdram_controller requests with a credit-guarded read return FIFO.
// Define SDRAM_SEQ_PERF_CNT_EN to add the perf_stall_cnt/perf_word_cnt counters.
module sdram_burst_sequencer #(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              seq_busy,
  output logic              sd_in_valid,
  output logic              sd_rw,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_wdata,
  input  logic              sd_busy,
  input  logic              sd_out_valid,
  input  logic [DATA_W-1:0] sd_rdata
`ifdef SDRAM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_word_cnt
`endif
);
  localparam int PW = $clog2(RFIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [2:0] {IDLE, ISSUE, PULSE, DRAIN, DONE} state_t;
  state_t state;
  logic rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] remain_q;
  logic [CW-1:0] outstanding, fifo_cnt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [DATA_W-1:0] fifo_mem [RFIFO_DEPTH];
  logic issue, pop, credit_ok;
  // Reads in flight plus words already buffered may never exceed the FIFO depth.
  assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, outstanding}) < (CW+1)'(RFIFO_DEPTH);
  assign issue = state == ISSUE && !sd_busy && (rw_q ? wr_valid : credit_ok);
  assign pop = rd_valid && rd_ready;
  assign wr_ready = issue && rw_q;
  assign cmd_ready = state == IDLE && rst_n;
  assign seq_busy = state != IDLE;
  assign rd_valid = fifo_cnt != '0;
  assign rd_data = fifo_mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rw_q <= 1'b0;
      addr_q <= '0;
      remain_q <= '0;
      outstanding <= '0;
      fifo_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      sd_in_valid <= 1'b0;
      sd_rw <= 1'b0;
      sd_addr <= '0;
      sd_wdata <= '0;
      done <= 1'b0;
    end else begin
      sd_in_valid <= issue;
      done <= state == DONE;
      if (issue) begin
        sd_rw <= rw_q;
        sd_addr <= addr_q;
        sd_wdata <= wr_data;
        addr_q <= addr_q + ADDR_W'(1);
        remain_q <= remain_q - LEN_W'(1);
      end
      outstanding <= outstanding + CW'(issue && !rw_q) - CW'(sd_out_valid);
      fifo_cnt <= fifo_cnt + CW'(sd_out_valid) - CW'(pop);
      if (sd_out_valid) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case (state)
        IDLE: if (cmd_valid) begin
          rw_q <= cmd_rw;
          addr_q <= cmd_addr;
          remain_q <= cmd_len;
          state <= cmd_len == '0 ? DONE : ISSUE;
        end
        ISSUE: if (issue) state <= PULSE;
        PULSE: state <= remain_q != '0 ? ISSUE : rw_q ? DONE : DRAIN;
        DRAIN: if (outstanding == '0) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && sd_out_valid) fifo_mem[wr_ptr] <= sd_rdata;
    if (rst_n && sd_out_valid && !pop) assert (fifo_cnt < CW'(RFIFO_DEPTH));
  end
`ifdef SDRAM_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_word_cnt <= '0;
    end else begin
      if (state == ISSUE && sd_busy && ~&perf_stall_cnt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (issue && ~&perf_word_cnt) perf_word_cnt <= perf_word_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// tb_sdram_burst_sequencer: randomized bench with a queue-based burst/memory reference and a latency-randomized controller model.
module tb_sdram_burst_sequencer;
  localparam int AW = 23, DW = 32, LW = 16, DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_rw = 0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic wr_valid = 0, wr_ready, rd_valid, rd_ready = 0, done, seq_busy;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic sd_in_valid, sd_rw, sd_busy = 0, sd_out_valid = 0;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_wdata, sd_rdata = '0;
`ifdef SDRAM_SEQ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_word_cnt;
`endif
  always #5 clk = ~clk;

  sdram_burst_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .done(done), .seq_busy(seq_busy),
    .sd_in_valid(sd_in_valid), .sd_rw(sd_rw), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_busy(sd_busy), .sd_out_valid(sd_out_valid), .sd_rdata(sd_rdata)
`ifdef SDRAM_SEQ_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_word_cnt(perf_word_cnt)
`endif
  );

  typedef struct {logic rw; logic [AW-1:0] addr; logic [DW-1:0] data;} iss_t;
  typedef struct {logic rw; logic [AW-1:0] addr; logic [DW-1:0] data; int due;} req_t;
  iss_t exp_iss[$];
  req_t pend[$];
  logic [DW-1:0] exp_rd[$], feed[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] sd_mem [logic [AW-1:0]];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = -1, first_lat = 0, last_iss = 0, last_done = 0;
  int issues = 0, words_rst = 0, dones = 0, d_start = 0, rd_out = 0;
  int wr_p = 100, rd_p = 100, busy_p = 25, lat_max = 4;
  bit prev_wr = 0, prev_siv = 0, first_iss = 0, peak_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {9'h0, a} ^ 32'hC0DE_0000;
  endfunction

  // Controller model: one request queue, in-order completion after a random latency.
  task automatic drive();
    req_t r;
    sd_out_valid = 0;
    sd_rdata = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      if (r.rw) sd_mem[r.addr] = r.data;
      else begin
        sd_out_valid = 1;
        sd_rdata = sd_mem.exists(r.addr) ? sd_mem[r.addr] : init_val(r.addr);
      end
    end
    sd_busy = pend.size() >= 2 || $urandom_range(0, 99) < busy_p;
    wr_valid = feed.size() > 0 && $urandom_range(0, 99) < wr_p;
    wr_data = feed.size() > 0 ? feed[0] : $urandom;
    rd_ready = $urandom_range(0, 99) < rd_p;
  endtask

  task automatic monitor();
    iss_t e;
    cyc++;
    if (!rst_n) return;
    if (cmd_valid && cmd_ready) begin
      acc_cyc = cyc;
      first_iss = 1;
    end
    if (prev_wr) check("wr_to_issue", sd_in_valid, 1);
    if (wr_ready) check("wr_ready_needs_valid", wr_valid, 1);
    prev_wr = wr_ready && wr_valid;
    if (wr_ready && wr_valid) void'(feed.pop_front());
    if (sd_in_valid) begin
      check("pulse_one_cycle", prev_siv, 0);
      if (first_iss) begin
        first_lat = cyc - acc_cyc;
        check("accept_to_issue", first_lat >= 2, 1);
        first_iss = 0;
      end else if (peak_chk) check("peak_gap", cyc - last_iss, 2);
      last_iss = cyc;
      check("issue_expected", exp_iss.size() > 0, 1);
      if (exp_iss.size() > 0) begin
        e = exp_iss.pop_front();
        check("sd_rw", sd_rw, e.rw);
        check("sd_addr", sd_addr, e.addr);
        if (e.rw) check("sd_wdata", sd_wdata, e.data);
      end
      if (!sd_rw) begin
        rd_out++;
        check("credit", rd_out <= DEPTH, 1);
      end
      issues++;
      words_rst++;
      pend.push_back('{sd_rw, sd_addr, sd_wdata, cyc + int'($urandom_range(1, lat_max))});
    end
    prev_siv = sd_in_valid;
    if (rd_valid && rd_ready) begin
      check("rd_expected", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
      rd_out--;
    end
    if (done) begin
      dones++;
      last_done = cyc;
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input bit rw, input logic [AW-1:0] a, input int len, input bit fixed, input logic [DW-1:0] dbase);
    logic [AW-1:0] ai;
    logic [DW-1:0] v;
    for (int i = 0; i < len; i++) begin
      ai = a + AW'(i);
      if (rw) begin
        v = fixed ? dbase + DW'(i) : $urandom;
        ref_mem[ai] = v;
        feed.push_back(v);
      end else begin
        v = ref_mem.exists(ai) ? ref_mem[ai] : init_val(ai);
        exp_rd.push_back(v);
      end
      exp_iss.push_back('{rw, ai, v});
    end
    d_start = dones;
    acc_cyc = -1;
    cmd_valid = 1;
    cmd_rw = rw;
    cmd_addr = a;
    cmd_len = LW'(len);
    for (int k = 0; k < 50 && acc_cyc < 0; k++) cycle();
    cmd_valid = 0;
    check("cmd_accept", acc_cyc >= 0, 1);
  endtask

  task automatic finish_burst(input int budget);
    for (int k = 0; k < budget && dones == d_start; k++) cycle();
    check("done_seen", dones - d_start, 1);
    repeat (3) cycle();
    check("done_single", dones - d_start, 1);
    check("issues_left", exp_iss.size(), 0);
  endtask

  task automatic wait_issues(input int n);
    for (int k = 0; k < 300 && issues < n; k++) cycle();
    check("wait_issues", issues >= n, 1);
  endtask

  task automatic drain();
    rd_p = 100;
    for (int k = 0; k < 300 && (rd_out != 0 || pend.size() != 0); k++) cycle();
    check("drain", rd_out, 0);
  endtask

  task automatic reset_dut();
    rst_n = 0;
    cmd_valid = 0;
    pend.delete();
    exp_iss.delete();
    exp_rd.delete();
    feed.delete();
    rd_out = 0;
    words_rst = 0;
    prev_wr = 0;
    prev_siv = 0;
    first_iss = 0;
    cycle();
    cycle();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_sd_in_valid", sd_in_valid, 0);
    check("rst_sd_rw", sd_rw, 0);
    check("rst_sd_addr", sd_addr, 0);
    check("rst_sd_wdata", sd_wdata, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_seq_busy", seq_busy, 0);
    rst_n = 1;
    cycle();
    check("cmd_ready_after_rst", cmd_ready, 1);
  endtask

  initial begin
    int i0, d0;
    reset_dut();
    busy_p = 0;
    lat_max = 1;
    peak_chk = 1;
    launch(1, 23'h000100, 4, 1, 32'hA0);
    finish_burst(200);
    check("wr_first_lat", first_lat, 2);
    launch(0, 23'h000100, 4, 0, 0);
    finish_burst(200);
    check("rd_first_lat", first_lat, 2);
    drain();
    check("rd_back_consumed", exp_rd.size(), 0);
    peak_chk = 0;
    busy_p = 25;
    lat_max = 4;
    rd_p = 0;
    i0 = issues;
    launch(0, 23'h002000, 8, 0, 0);
    repeat (40) cycle();
    check("bp_issues", issues - i0, 4);
    rd_p = 100;
    finish_burst(500);
    drain();
    launch(1, 23'h7FFFFE, 4, 0, 0);
    finish_burst(300);
    i0 = issues;
    launch(1, 23'h000055, 0, 0, 0);
    finish_burst(50);
    check("len0_wr_latency", last_done - acc_cyc, 2);
    launch(0, 23'h000055, 0, 0, 0);
    finish_burst(50);
    check("len0_rd_latency", last_done - acc_cyc, 2);
    check("len0_no_issue", issues - i0, 0);
    i0 = issues;
    launch(1, 23'h000300, 6, 0, 0);
    wait_issues(i0 + 2);
    wr_p = 0;
    repeat (10) begin
      cycle();
      check("stall_sd_in_valid", sd_in_valid, 0);
      check("stall_wr_ready", wr_ready, 0);
    end
    wr_p = 100;
    finish_burst(300);
    drain();
    i0 = issues;
    launch(0, 23'h7FFFFE, 6, 0, 0);
    wait_issues(i0 + 2);
    d0 = dones;
    reset_dut();
    repeat (5) cycle();
    check("rst_no_done", dones - d0, 0);
    launch(0, 23'h7FFFFE, 6, 0, 0);
    finish_burst(400);
    drain();
    wr_p = 70;
    rd_p = 60;
    repeat (12) begin
      launch($urandom_range(0, 1), AW'(23'h7FFFF0 + $urandom_range(0, 31)), $urandom_range(0, 9), 0, 0);
      finish_burst(600);
    end
    drain();
    check("rd_all_consumed", exp_rd.size(), 0);
`ifdef SDRAM_SEQ_PERF_CNT_EN
    check("perf_words", perf_word_cnt, words_rst);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
